// File: rtl/regfile_multi_seq.sv
// LDM/STM sequencer: walks a register list one beat per mem_req/mem_ready handshake, then optional base writeback.
// Latency: N beats (+1 WB) + 1 DONE cycle after start; beats hold all request outputs while mem_ready is low.
module regfile_multi_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load,
  input  logic [15:0] reglist,
  input  logic [31:0] base,
  input  logic [3:0]  rn,
  input  logic        pre,
  input  logic        up,
  input  logic        wback,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  reg_ra,
  input  logic [31:0] reg_rdata,
  output logic        reg_we,
  output logic [3:0]  reg_wa,
  output logic [31:0] reg_wd
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] mask;
  logic [31:0] addr;
  logic [31:0] wb_val;
  logic [3:0]  rn_q;
  logic        load_q;
  logic        wb_go;

  logic [4:0]  cnt;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [3:0]  cur;
  logic        last;
  logic        beat;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, reglist[i]};
  end

  assign span = {25'd0, cnt, 2'b00};

  always_comb begin
    case ({pre, up})
      2'b01:   start_addr = base;
      2'b11:   start_addr = base + 32'd4;
      2'b00:   start_addr = base - span + 32'd4;
      default: start_addr = base - span;
    endcase
  end

  // Downward scan so the lowest set bit is the one left standing.
  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) cur = 4'(i);
    end
  end

  assign last = ((mask & (mask - 16'd1)) == 16'd0);
  assign beat = (state == XFER) && mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mask   <= '0;
      addr   <= '0;
      wb_val <= '0;
      rn_q   <= '0;
      load_q <= 1'b0;
      wb_go  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        mask   <= reglist;
        addr   <= start_addr;
        wb_val <= up ? (base + span) : (base - span);
        rn_q   <= rn;
        load_q <= load;
        // A loaded Rn beats the writeback value.
        wb_go  <= wback && !(load && reglist[rn]);
      end else if (beat) begin
        mask <= mask & (mask - 16'd1);
        addr <= addr + 32'd4;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    reg_wa    = '0;
    reg_wd    = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (reglist == 16'd0) ? DONE : XFER;
      end
      XFER: begin
        mem_req = 1'b1;
        mem_we  = !load_q;
        reg_we  = load_q && mem_ready;
        reg_wa  = cur;
        reg_wd  = mem_rdata;
        if (mem_ready && last) state_nxt = wb_go ? WB : DONE;
      end
      WB: begin
        reg_we    = 1'b1;
        reg_wa    = rn_q;
        reg_wd    = wb_val;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = addr;
  assign reg_ra    = cur;
  assign mem_wdata = reg_rdata;

endmodule
